// File: rtl/result_unloader_if.sv
// Core/host handshake bundle for result_unloader. The master modport is the
// unloader side; the slave modport is the core/host side.
interface result_unloader_if;
  logic               ena;
  logic signed [31:0] result;
  logic               result_valid;
  logic               out_ack;
  logic        [7:0]  out_pins;
  logic               out_valid;
  logic               out_last;
  logic               unload_busy;
  logic               overrun;

  modport master (
    input  ena, result, result_valid, out_ack,
    output out_pins, out_valid, out_last, unload_busy, overrun
  );

  modport slave (
    output ena, result, result_valid, out_ack,
    input  out_pins, out_valid, out_last, unload_busy, overrun
  );
endinterface

// File: rtl/result_unloader.sv
// Serialises a 32-bit core result into little-endian bytes over a valid/ack
// handshake. Define UNLOAD_CHECKSUM_EN to append an XOR checksum byte.
module result_unloader #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  result_unloader_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef UNLOAD_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  cnt_inc;
  logic [31:0] shadow_q, shadow_d;
  logic [7:0]  pins_q, pins_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  function automatic logic [7:0] byte_at(input logic [31:0] s, input logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0:    b = s[7:0];
      3'd1:    b = s[15:8];
      3'd2:    b = s[23:16];
      3'd3:    b = s[31:24];
`ifdef UNLOAD_CHECKSUM_EN
      3'd4:    b = s[7:0] ^ s[15:8] ^ s[23:16] ^ s[31:24];
`endif
      default: b = IDLE_BYTE;
    endcase
    return b;
  endfunction

  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a variable unassigned,
    // which would otherwise infer a latch; it also makes ena=0 a plain hold.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    pins_d    = pins_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    cnt_inc   = cnt_q + 3'd1;

    if (bus.ena) begin
      unique case (state_q)
        IDLE: begin
          if (bus.result_valid) begin
            shadow_d  = bus.result;
            cnt_d     = 3'd0;
            overrun_d = 1'b0;
            pins_d    = bus.result[7:0];
            valid_d   = 1'b1;
            last_d    = 1'b0;
            busy_d    = 1'b1;
            state_d   = SEND;
          end
        end

        SEND: begin
          // A new result cannot be taken mid-frame; it is dropped and flagged.
          if (bus.result_valid) overrun_d = 1'b1;
          if (valid_q && bus.out_ack) begin
            if (cnt_q == LAST_IDX) begin
              pins_d  = IDLE_BYTE;
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = DONE;
            end else begin
              cnt_d  = cnt_inc;
              pins_d = byte_at(shadow_q, cnt_inc);
              last_d = (cnt_inc == LAST_IDX);
            end
          end
        end

        DONE: begin
          if (bus.result_valid) overrun_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end

        default: begin
          pins_d  = IDLE_BYTE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      shadow_q  <= 32'd0;
      pins_q    <= IDLE_BYTE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      pins_q    <= pins_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_pins    = pins_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_last    = last_q;
  assign bus.unload_busy = busy_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_result_unloader.sv
// Directed self-checking bench for result_unloader; expected bytes are
// hand-computed constants. Works with or without UNLOAD_CHECKSUM_EN.
module tb_result_unloader;

  localparam logic [7:0] IDLE = 8'hC3;

`ifdef UNLOAD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  result_unloader_if bus ();

  result_unloader #(.IDLE_BYTE(IDLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic show(input string tag, input logic [7:0] b, input logic last);
    check({tag, " valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, " pins"}, {24'd0, bus.out_pins}, {24'd0, b});
    check({tag, " last"}, {31'd0, bus.out_last}, {31'd0, last});
    check({tag, " busy"}, {31'd0, bus.unload_busy}, 32'd1);
  endtask

  // Expects byte 3 on the pins with out_ack high; walks through the optional
  // checksum byte, DONE and back to IDLE. rv_end strobes result_valid on the
  // final ack edge.
  task automatic finish_frame(input string tag, input logic [7:0] b3,
                              input logic [7:0] csum, input logic rv_end,
                              input logic exp_ovr);
    show({tag, " b3"}, b3, !CSUM);
    if (CSUM) begin
      step();
      show({tag, " csum"}, csum, 1'b1);
    end
    bus.result_valid = rv_end;
    step();
    bus.result_valid = 1'b0;
    check({tag, " done valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " done last"}, {31'd0, bus.out_last}, 32'd0);
    check({tag, " done pins"}, {24'd0, bus.out_pins}, {24'd0, IDLE});
    check({tag, " done busy"}, {31'd0, bus.unload_busy}, 32'd1);
    step();
    check({tag, " idle busy"}, {31'd0, bus.unload_busy}, 32'd0);
    check({tag, " idle valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, " idle ovr"}, {31'd0, bus.overrun}, {31'd0, exp_ovr});
  endtask

  task automatic capture(input logic [31:0] value);
    bus.result       = value;
    bus.result_valid = 1'b1;
    step();
    bus.result_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst              = 1'b1;
    bus.ena          = 1'b1;
    bus.result       = 32'h0;
    bus.result_valid = 1'b0;
    bus.out_ack      = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset last", {31'd0, bus.out_last}, 32'd0);
    check("reset pins", {24'd0, bus.out_pins}, {24'd0, IDLE});
    check("reset busy", {31'd0, bus.unload_busy}, 32'd0);
    check("reset ovr", {31'd0, bus.overrun}, 32'd0);
    step();
    check("idle no frame", {31'd0, bus.out_valid}, 32'd0);

    // Basic frame, ack tied high: 78 56 34 12 (+08).
    bus.out_ack = 1'b1;
    capture(32'h12345678);
    show("f1 b0", 8'h78, 1'b0);
    step();
    show("f1 b1", 8'h56, 1'b0);
    step();
    show("f1 b2", 8'h34, 1'b0);
    step();
    finish_frame("f1", 8'h12, 8'h08, 1'b0, 1'b0);

    // Negative result is sent unchanged: FF FF FF FF (+00).
    capture(32'hFFFFFFFF);
    show("f2 b0", 8'hFF, 1'b0);
    step();
    show("f2 b1", 8'hFF, 1'b0);
    step();
    show("f2 b2", 8'hFF, 1'b0);
    step();
    finish_frame("f2", 8'hFF, 8'h00, 1'b0, 1'b0);

    // Host stalls 3 cycles on byte 1.
    capture(32'h12345678);
    show("f3 b0", 8'h78, 1'b0);
    step();
    bus.out_ack = 1'b0;
    show("f3 stall0", 8'h56, 1'b0);
    step();
    show("f3 stall1", 8'h56, 1'b0);
    step();
    show("f3 stall2", 8'h56, 1'b0);
    bus.out_ack = 1'b1;
    step();
    show("f3 b2", 8'h34, 1'b0);
    step();
    finish_frame("f3", 8'h12, 8'h08, 1'b0, 1'b0);

    // Second strobe during SEND is dropped and flags overrun.
    capture(32'h12345678);
    show("f4 b0", 8'h78, 1'b0);
    check("f4 ovr before", {31'd0, bus.overrun}, 32'd0);
    capture(32'hAAAAAAAA);
    show("f4 b1", 8'h56, 1'b0);
    check("f4 ovr set", {31'd0, bus.overrun}, 32'd1);
    step();
    show("f4 b2", 8'h34, 1'b0);
    step();
    finish_frame("f4", 8'h12, 8'h08, 1'b0, 1'b1);

    // Next capture clears overrun; a strobe on the final ack edge sets it again.
    capture(32'h80000001);
    show("f5 b0", 8'h01, 1'b0);
    check("f5 ovr cleared", {31'd0, bus.overrun}, 32'd0);
    step();
    show("f5 b1", 8'h00, 1'b0);
    step();
    show("f5 b2", 8'h00, 1'b0);
    step();
    finish_frame("f5", 8'h80, 8'h81, 1'b1, 1'b1);

    // ena low for 4 cycles mid-frame with ack high freezes everything.
    capture(32'h12345678);
    show("f6 b0", 8'h78, 1'b0);
    check("f6 ovr cleared", {31'd0, bus.overrun}, 32'd0);
    step();
    show("f6 b1", 8'h56, 1'b0);
    bus.ena = 1'b0;
    step();
    show("f6 frz0", 8'h56, 1'b0);
    step();
    show("f6 frz1", 8'h56, 1'b0);
    step();
    show("f6 frz2", 8'h56, 1'b0);
    step();
    show("f6 frz3", 8'h56, 1'b0);
    bus.ena = 1'b1;
    step();
    show("f6 b2", 8'h34, 1'b0);
    step();
    finish_frame("f6", 8'h12, 8'h08, 1'b0, 1'b0);

    // Reset while byte 2 is offered abandons the frame.
    capture(32'h12345678);
    show("f7 b0", 8'h78, 1'b0);
    capture(32'hAAAAAAAA);
    show("f7 b1", 8'h56, 1'b0);
    check("f7 ovr set", {31'd0, bus.overrun}, 32'd1);
    step();
    show("f7 b2", 8'h34, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("f7 rst valid", {31'd0, bus.out_valid}, 32'd0);
    check("f7 rst busy", {31'd0, bus.unload_busy}, 32'd0);
    check("f7 rst pins", {24'd0, bus.out_pins}, {24'd0, IDLE});
    check("f7 rst ovr", {31'd0, bus.overrun}, 32'd0);
    check("f7 rst last", {31'd0, bus.out_last}, 32'd0);
    step();
    step();
    check("f7 post valid", {31'd0, bus.out_valid}, 32'd0);
    check("f7 post pins", {24'd0, bus.out_pins}, {24'd0, IDLE});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
